// File: rtl/scrambled_ram_ctrl.sv
// Scrambled 32-bit SPRAM controller: address/data scrambling over N bank pairs of
// 16K x 16 SPRAM, with a clear engine that zeroizes every logical word.

module scrambled_ram_ctrl #(
  parameter int unsigned  BANK_SEL_BITS  = 1,
  parameter bit           CLEAR_ON_RESET = 1'b1,
  localparam int unsigned ADDR_WIDTH     = 14 + BANK_SEL_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] ram_addr_rand,
  input  logic [31:0]           ram_data_rand,
  input  logic                  clear_req,
  input  logic                  cs,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  clear_done
);

  localparam int unsigned BW    = (BANK_SEL_BITS > 0) ? BANK_SEL_BITS : 1;
  localparam int unsigned NBANK = 1 << BANK_SEL_BITS;
  localparam int unsigned NSLOT = 1 << BW;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  state_r, state_next_s;
  logic [ADDR_WIDTH-1:0]   counter_r, counter_next_s;
  logic                    clear_pending_r, clear_pending_next_s;
  logic                    ready_r, ready_next_s;
  logic                    busy_r, busy_next_s;
  logic                    clear_done_r, clear_done_next_s;
  logic [BW-1:0]           bank_sel_r;

  logic                    access_s;
  logic                    mem_en_s;
  logic [ADDR_WIDTH-1:0]   phys_addr_s;
  logic [3:0]              mem_we_s;
  logic [31:0]             mem_wdata_s;
  logic [BW-1:0]           bank_s;
  logic [NSLOT-1:0]        bank_cs_s;
  logic [NSLOT-1:0][31:0]  bank_rdata_s;

  function automatic logic [31:0] tweak_f(input logic [ADDR_WIDTH-1:0] logical);
    logic [15:0] wide;
    wide = 16'(logical);
    return {wide, wide};
  endfunction

  // Datapath source select: clear engine owns the RAM port while clearing
  always_comb begin
    access_s    = (state_r == ST_IDLE) && cs && !ready_r;
    mem_en_s    = access_s || (state_r == ST_CLEAR);
    phys_addr_s = address ^ ram_addr_rand;
    mem_we_s    = we;
    mem_wdata_s = write_data ^ ram_data_rand ^ tweak_f(address);
    if (state_r == ST_CLEAR) begin
      // Stored value descrambles to zero at the logical address mapping here
      phys_addr_s = counter_r;
      mem_we_s    = 4'hF;
      mem_wdata_s = ram_data_rand ^ tweak_f(counter_r ^ ram_addr_rand);
    end else begin
      mem_we_s    = we;
    end
  end

  // Next-state and registered-output decode for the clear engine
  always_comb begin
    state_next_s         = state_r;
    counter_next_s       = counter_r;
    clear_pending_next_s = clear_pending_r | clear_req;
    case (state_r)
      ST_IDLE: begin
        if (clear_pending_r && (!cs || ready_r)) begin
          state_next_s         = ST_CLEAR;
          counter_next_s       = {ADDR_WIDTH{1'b0}};
          clear_pending_next_s = 1'b0;
        end else begin
          state_next_s         = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clear_pending_next_s = 1'b0;
        if (clear_req) begin
          counter_next_s = {ADDR_WIDTH{1'b0}};
        end else if (counter_r == LAST_WORD) begin
          state_next_s   = ST_IDLE;
          counter_next_s = {ADDR_WIDTH{1'b0}};
        end else begin
          counter_next_s = counter_r + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        counter_next_s = {ADDR_WIDTH{1'b0}};
      end
    endcase
    ready_next_s      = access_s;
    busy_next_s       = (state_next_s == ST_CLEAR);
    clear_done_next_s = (state_next_s == ST_CLEAR) && (counter_next_s == LAST_WORD);
  end

  // State, counter and status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      counter_r       <= {ADDR_WIDTH{1'b0}};
      clear_pending_r <= CLEAR_ON_RESET;
      ready_r         <= 1'b0;
      busy_r          <= 1'b0;
      clear_done_r    <= 1'b0;
      bank_sel_r      <= {BW{1'b0}};
    end else begin
      state_r         <= state_next_s;
      counter_r       <= counter_next_s;
      clear_pending_r <= clear_pending_next_s;
      ready_r         <= ready_next_s;
      busy_r          <= busy_next_s;
      clear_done_r    <= clear_done_next_s;
      if (access_s) begin
        bank_sel_r <= bank_s;
      end
    end
  end

  if (BANK_SEL_BITS > 0) begin : g_bank_sel
    assign bank_s = phys_addr_s[ADDR_WIDTH-1:14];
  end else begin : g_single_bank
    assign bank_s = {BW{1'b0}};
  end

  for (genvar b = 0; b < NSLOT; b++) begin : g_bank
    if (b < NBANK) begin : g_pair
      assign bank_cs_s[b] = mem_en_s && (bank_s == BW'(b));

      scrambled_ram_spram256ka u_lo (
        .ADDRESS    (phys_addr_s[13:0]),
        .DATAIN     (mem_wdata_s[15:0]),
        .MASKWREN   ({mem_we_s[1], mem_we_s[1], mem_we_s[0], mem_we_s[0]}),
        .WREN       (mem_we_s[1] | mem_we_s[0]),
        .CHIPSELECT (bank_cs_s[b]),
        .CLOCK      (clk),
        .STANDBY    (1'b0),
        .SLEEP      (1'b0),
        .POWEROFF   (1'b1),
        .DATAOUT    (bank_rdata_s[b][15:0])
      );

      scrambled_ram_spram256ka u_hi (
        .ADDRESS    (phys_addr_s[13:0]),
        .DATAIN     (mem_wdata_s[31:16]),
        .MASKWREN   ({mem_we_s[3], mem_we_s[3], mem_we_s[2], mem_we_s[2]}),
        .WREN       (mem_we_s[3] | mem_we_s[2]),
        .CHIPSELECT (bank_cs_s[b]),
        .CLOCK      (clk),
        .STANDBY    (1'b0),
        .SLEEP      (1'b0),
        .POWEROFF   (1'b1),
        .DATAOUT    (bank_rdata_s[b][31:16])
      );
    end else begin : g_empty
      assign bank_cs_s[b]    = 1'b0;
      assign bank_rdata_s[b] = 32'h0000_0000;
    end
  end

  assign read_data  = bank_rdata_s[bank_sel_r] ^ ram_data_rand ^ tweak_f(address);
  assign ready      = ready_r;
  assign busy       = busy_r;
  assign clear_done = clear_done_r;

endmodule

// Behavioural stand-in for SB_SPRAM256KA (16K x 16, nibble write masks);
// port names match the primitive so the instances can be retargeted directly.
module scrambled_ram_spram256ka (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] mem_r [16384];

  // Synchronous nibble-masked write, registered read
  always_ff @(posedge CLOCK) begin
    if (CHIPSELECT && !STANDBY && !SLEEP && POWEROFF) begin
      if (WREN) begin
        for (int i = 0; i < 4; i++) begin
          if (MASKWREN[i]) begin
            mem_r[ADDRESS][4*i +: 4] <= DATAIN[4*i +: 4];
          end
        end
      end else begin
        DATAOUT <= mem_r[ADDRESS];
      end
    end
  end

endmodule

// File: tb/tb_scrambled_ram_ctrl.sv
// Directed bench: dut1 (two bank pairs) covers access paths, dut0 (one pair)
// covers clear restart, stalled access and reset abort.

module tb_scrambled_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // dut1: BANK_SEL_BITS=1
  logic        a_reset_n, a_clear_req, a_cs;
  logic [14:0] a_addr_rand, a_address;
  logic [31:0] a_data_rand, a_write_data, a_read_data;
  logic [3:0]  a_we;
  logic        a_ready, a_busy, a_clear_done;

  // dut0: BANK_SEL_BITS=0
  logic        b_reset_n, b_clear_req, b_cs;
  logic [13:0] b_addr_rand, b_address;
  logic [31:0] b_data_rand, b_write_data, b_read_data;
  logic [3:0]  b_we;
  logic        b_ready, b_busy, b_clear_done;

  logic [14:0] a_phys;
  logic [1:0]  a_bcs;
  logic        a_after;

  scrambled_ram_ctrl #(.BANK_SEL_BITS(1), .CLEAR_ON_RESET(1'b1)) dut1 (
    .clk(clk), .reset_n(a_reset_n), .ram_addr_rand(a_addr_rand), .ram_data_rand(a_data_rand),
    .clear_req(a_clear_req), .cs(a_cs), .we(a_we), .address(a_address),
    .write_data(a_write_data), .read_data(a_read_data), .ready(a_ready),
    .busy(a_busy), .clear_done(a_clear_done)
  );

  scrambled_ram_ctrl #(.BANK_SEL_BITS(0), .CLEAR_ON_RESET(1'b1)) dut0 (
    .clk(clk), .reset_n(b_reset_n), .ram_addr_rand(b_addr_rand), .ram_data_rand(b_data_rand),
    .clear_req(b_clear_req), .cs(b_cs), .we(b_we), .address(b_address),
    .write_data(b_write_data), .read_data(b_read_data), .ready(b_ready),
    .busy(b_busy), .clear_done(b_clear_done)
  );

  task automatic a_access(input logic [14:0] addr, input logic [3:0] wen,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    a_cs = 1'b1; a_we = wen; a_address = addr; a_write_data = wdata;
    #1;
    a_phys = dut1.phys_addr_s;
    a_bcs  = dut1.bank_cs_s;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (a_ready) break;
    end
    rdata = a_read_data;
    a_cs = 1'b0; a_we = 4'h0;
    @(negedge clk);
    a_after = a_ready;
  endtask

  task automatic test_reset();
    int busy_cnt = 0, done_cnt = 0, cyc = 0;
    bit seen = 1'b0;
    a_reset_n = 1'b0; b_reset_n = 1'b0;
    a_clear_req = 1'b0; a_cs = 1'b0; a_we = 4'h0; a_address = '0; a_write_data = '0;
    b_clear_req = 1'b0; b_cs = 1'b0; b_we = 4'h0; b_address = '0; b_write_data = '0;
    a_addr_rand = 15'h1234; a_data_rand = 32'hDEADBEEF;
    b_addr_rand = 14'h0ABC; b_data_rand = 32'h5A5A5A5A;
    repeat (3) @(negedge clk);
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", a_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_clear_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", a_clear_done); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy0 got=%b exp=0", b_busy); end
    a_reset_n = 1'b1; b_reset_n = 1'b1;
    while (cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (a_busy) begin busy_cnt++; seen = 1'b1; end
      if (a_clear_done) done_cnt++;
      if (seen && !a_busy) break;
    end
    checks++; if (cyc >= 40000) begin errors++; $display("FAIL reset_clear_timeout got=%0d exp<40000", cyc); end
    checks++; if (busy_cnt != 32768) begin errors++; $display("FAIL reset_clear_len got=%0d exp=32768", busy_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL reset_clear_done got=%0d exp=1", done_cnt); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_clear0_busy got=%b exp=0", b_busy); end
  endtask

  task automatic test_cleared_reads();
    logic [14:0] addrs [4] = '{15'h0000, 15'h3FFF, 15'h4000, 15'h7FFF};
    logic [31:0] rd;
    int lat;
    for (int i = 0; i < 4; i++) begin
      a_access(addrs[i], 4'h0, 32'h0, rd, lat);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cleared_read[%0h] got=%h exp=00000000", addrs[i], rd); end
      checks++; if (lat != 1) begin errors++; $display("FAIL cleared_lat[%0h] got=%0d exp=1", addrs[i], lat); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int lat;
    a_access(15'h0010, 4'hF, 32'hCAFEBABE, rd, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL wr_lat got=%0d exp=1", lat); end
    checks++; if (a_phys !== 15'h1224) begin errors++; $display("FAIL wr_phys got=%h exp=1224", a_phys); end
    checks++; if (a_bcs !== 2'b01) begin errors++; $display("FAIL wr_bank_cs got=%b exp=01", a_bcs); end
    checks++; if (a_after !== 1'b0) begin errors++; $display("FAIL wr_ready_pulse got=%b exp=0", a_after); end
    a_access(15'h0010, 4'h0, 32'h0, rd, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL rd_lat got=%0d exp=1", lat); end
    checks++; if (rd !== 32'hCAFEBABE) begin errors++; $display("FAIL rd_data got=%h exp=cafebabe", rd); end
    checks++; if (a_phys !== 15'h1224) begin errors++; $display("FAIL rd_phys got=%h exp=1224", a_phys); end
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd;
    int lat;
    a_access(15'h0020, 4'hF, 32'h11223344, rd, lat);
    a_access(15'h0020, 4'h2, 32'h0000AA00, rd, lat);
    a_access(15'h0020, 4'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h1122AA44) begin errors++; $display("FAIL byte_lane got=%h exp=1122aa44", rd); end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    a_cs = 1'b1; a_we = 4'h0; a_address = 15'h0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (a_ready !== exp_rdy[i]) begin errors++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, a_ready, exp_rdy[i]); end
      if (exp_rdy[i]) begin
        checks++; if (a_read_data !== 32'hCAFEBABE) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=cafebabe", i, a_read_data); end
      end
    end
    a_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bank_select();
    logic [31:0] rd;
    int lat;
    a_addr_rand = 15'h4000; a_data_rand = 32'h0;
    a_access(15'h0001, 4'hF, 32'h13579BDF, rd, lat);
    checks++; if (a_bcs !== 2'b10) begin errors++; $display("FAIL bank_wr_cs got=%b exp=10", a_bcs); end
    checks++; if (a_phys !== 15'h4001) begin errors++; $display("FAIL bank_wr_phys got=%h exp=4001", a_phys); end
    a_access(15'h0001, 4'h0, 32'h0, rd, lat);
    checks++; if (a_bcs !== 2'b10) begin errors++; $display("FAIL bank_rd_cs got=%b exp=10", a_bcs); end
    checks++; if (rd !== 32'h13579BDF) begin errors++; $display("FAIL bank_rd_data got=%h exp=13579bdf", rd); end
  endtask

  task automatic test_clear_restart_stall();
    int n = 0, cyc = 0, done_cnt = 0, done_cyc = -1, ready_cyc = -1, rdy_busy = 0;
    bit restarted = 1'b0;
    logic [31:0] rd = 32'hFFFFFFFF;
    b_clear_req = 1'b1;
    @(negedge clk);
    b_clear_req = 1'b0;
    while (cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (b_busy) begin
        if (b_ready) rdy_busy++;
        if (b_clear_done) begin done_cnt++; done_cyc = cyc; end
        b_clear_req = (!restarted && n == 100);
        if (n == 100) restarted = 1'b1;
        n++;
      end else begin
        b_clear_req = 1'b0;
        if (b_ready) begin ready_cyc = cyc; rd = b_read_data; break; end
      end
      if (cyc == 4) begin b_cs = 1'b1; b_we = 4'h0; b_address = 14'h0005; end
    end
    b_clear_req = 1'b0; b_cs = 1'b0;
    checks++; if (cyc >= 40000) begin errors++; $display("FAIL restart_timeout got=%0d exp<40000", cyc); end
    checks++; if (n != 101 + 16384) begin errors++; $display("FAIL restart_busy_len got=%0d exp=%0d", n, 101 + 16384); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (rdy_busy != 0) begin errors++; $display("FAIL stall_ready_while_busy got=%0d exp=0", rdy_busy); end
    checks++; if (ready_cyc - done_cyc != 2) begin errors++; $display("FAIL stall_ready_delay got=%0d exp=2", ready_cyc - done_cyc); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL stall_read_data got=%h exp=00000000", rd); end
    @(negedge clk);
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_pulse got=%b exp=0", b_ready); end
  endtask

  task automatic test_reset_abort();
    int n = 0, cyc = 0, busy_cnt = 0, done_cnt = 0;
    bit seen = 1'b0;
    b_clear_req = 1'b1;
    @(negedge clk);
    b_clear_req = 1'b0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (b_busy) begin
        if (n == 500) begin b_reset_n = 1'b0; break; end
        n++;
      end
    end
    checks++; if (n != 500) begin errors++; $display("FAIL abort_reach got=%0d exp=500", n); end
    @(negedge clk);
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", b_busy); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", b_ready); end
    b_reset_n = 1'b1;
    cyc = 0;
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (b_busy) begin
        if (!seen) begin
          checks++; if (dut0.counter_r !== 14'h0) begin errors++; $display("FAIL abort_restart_cnt got=%h exp=0000", dut0.counter_r); end
        end
        busy_cnt++; seen = 1'b1;
      end
      if (b_clear_done) done_cnt++;
      if (seen && !b_busy) break;
    end
    checks++; if (busy_cnt != 16384) begin errors++; $display("FAIL abort_clear_len got=%0d exp=16384", busy_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_cleared_reads();
    test_write_read();
    test_byte_lane();
    test_back_to_back();
    test_bank_select();
    test_clear_restart_stall();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
